// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_pc_register.sv
// Program counter: load has priority over increment; wraps modulo 2^32.
module pc_register
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        load_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i;
    end else if (inc_i) begin
      pc_d = pc_q + INSTR_BYTES;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch with redirect, flush of in-flight
// requests and a one-entry output holding register.
module instr_fetch
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        misalign_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pending_q, pending_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         misalign_q, misalign_d;
  logic         pc_inc, pc_load;
  logic [31:0]  pc_target;
  logic [31:0]  pc_q;
  logic [31:0]  target_aligned;
  logic         target_misaligned;

  assign target_aligned    = {redirect_target[31:2], 2'b00};
  assign target_misaligned = (redirect_target[1:0] != 2'b00);

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (pc_inc),
    .load_i   (pc_load),
    .target_i (pc_target),
    .pc_o     (pc_q)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    misalign_d = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    pc_target  = target_aligned;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          misalign_d = target_misaligned;
          if (imem_ready) begin
            pc_load = 1'b1;
          end else begin
            // Memory needs the original request held until it is accepted.
            pending_d = target_aligned;
            state_d   = FLUSH;
          end
        end else if (imem_ready) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          misalign_d = target_misaligned;
          pc_load    = 1'b1;
          valid_d    = 1'b0;
          state_d    = FETCH;
        end else if (valid_q && instr_ready) begin
          pc_inc  = 1'b1;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      FLUSH: begin
        if (redirect_valid) begin
          misalign_d = target_misaligned;
          pending_d  = target_aligned;
        end
        if (imem_ready) begin
          pc_load   = 1'b1;
          pc_target = redirect_valid ? target_aligned : pending_q;
          state_d   = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= 32'h0;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req     = (state_q == FETCH) || (state_q == FLUSH);
  assign imem_addr    = pc_q;
  assign instr_valid  = valid_q;
  assign instruction  = valid_q ? instr_q : NOP_INSTR;
  assign pc           = pc_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, hold, flush, misalign,
// wrap and asynchronous reset scenarios with hand-computed expectations.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;

  instr_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_ready     (instr_ready),
    .instr_valid     (instr_valid),
    .instruction     (instruction),
    .pc              (pc),
    .misalign_err    (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_target = 32'h0; instr_ready = 1'b0;
    tick(); tick();
    total++;
    if ({imem_req, instr_valid, misalign_err} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=000", {imem_req, instr_valid, misalign_err});
    end
    total++;
    if (instruction !== NOP || pc !== 32'h0) begin
      bad++; $display("FAIL reset_data instr=%h pc=%h exp=%h/0", instruction, pc, NOP);
    end
    // Redirect presented during the IDLE cycle must be ignored.
    rst_n = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0081;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || misalign_err !== 1'b0) begin
      bad++; $display("FAIL idle_redirect req=%b addr=%h mis=%b exp=1/0/0", imem_req, imem_addr, misalign_err);
    end
    $display("reset: done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_sequential();
    imem_ready = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k) || instr_valid !== 1'b0) begin
        bad++; $display("FAIL seq_req%0d req=%b addr=%h valid=%b exp=1/%h/0", k, imem_req, imem_addr, instr_valid, 32'(4 * k));
      end
      imem_rdata = 32'hA000_0000 + 32'(k);
      tick();
      total++;
      if (instr_valid !== 1'b1 || instruction !== 32'hA000_0000 + 32'(k) || pc !== 32'(4 * k)) begin
        bad++; $display("FAIL seq_out%0d valid=%b instr=%h pc=%h", k, instr_valid, instruction, pc);
      end
      tick();
      $display("seq: fetch %0d at %h", k, 32'(4 * k));
    end
  endtask

  task automatic test_hold();
    logic ok;
    instr_ready = 1'b0; imem_rdata = 32'h1234_5678;
    tick();
    imem_rdata = 32'hFFFF_FFFF;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (instr_valid !== 1'b1 || instruction !== 32'h1234_5678 || pc !== 32'h0000_000C || imem_req !== 1'b0)
        ok = 1'b0;
      tick();
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL hold_stable valid=%b instr=%h pc=%h req=%b", instr_valid, instruction, pc, imem_req);
    end
    instr_ready = 1'b1; imem_ready = 1'b0;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instruction !== NOP) begin
      bad++; $display("FAIL hold_release req=%b addr=%h instr=%h exp=1/10/%h", imem_req, imem_addr, instruction, NOP);
    end
    $display("hold: done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_flush();
    logic ok;
    redirect_valid = 1'b1; redirect_target = 32'h0000_0100;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      redirect_valid = 1'b0;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL flush_hold req=%b addr=%h exp=1/10", imem_req, imem_addr);
    end
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    total++;
    if (imem_addr !== 32'h100 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
      bad++; $display("FAIL flush_drop addr=%h valid=%b req=%b exp=100/0/1", imem_addr, instr_valid, imem_req);
    end
    imem_rdata = 32'h0000_0100;
    tick();
    total++;
    if (instr_valid !== 1'b1 || instruction !== 32'h0000_0100 || pc !== 32'h100) begin
      bad++; $display("FAIL flush_next valid=%b instr=%h pc=%h", instr_valid, instruction, pc);
    end
    $display("flush: done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_misalign();
    // Redirect in HOLD outranks the same-cycle accept.
    redirect_valid = 1'b1; redirect_target = 32'h0000_0202; imem_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (imem_addr !== 32'h200 || instr_valid !== 1'b0 || misalign_err !== 1'b1) begin
      bad++; $display("FAIL misalign_redirect addr=%h valid=%b mis=%b exp=200/0/1", imem_addr, instr_valid, misalign_err);
    end
    tick();
    total++;
    if (misalign_err !== 1'b0) begin
      bad++; $display("FAIL misalign_pulse mis=%b exp=0", misalign_err);
    end
    $display("misalign: done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC; imem_ready = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (imem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0 || misalign_err !== 1'b0) begin
      bad++; $display("FAIL fetch_redirect addr=%h valid=%b mis=%b", imem_addr, instr_valid, misalign_err);
    end
    imem_rdata = 32'h0BAD_F00D;
    tick();
    total++;
    if (instr_valid !== 1'b1 || pc !== 32'hFFFF_FFFC || instruction !== 32'h0BAD_F00D) begin
      bad++; $display("FAIL wrap_hold valid=%b pc=%h instr=%h", instr_valid, pc, instruction);
    end
    imem_ready = 1'b0;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_addr req=%b addr=%h exp=1/0", imem_req, imem_addr);
    end
    $display("wrap: done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_latest_wins();
    redirect_valid = 1'b1; redirect_target = 32'h0000_0300;
    tick();
    redirect_target = 32'h0000_0400;
    tick();
    redirect_valid = 1'b0; imem_ready = 1'b1;
    tick();
    total++;
    if (imem_addr !== 32'h400 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL latest_wins addr=%h req=%b valid=%b exp=400/1/0", imem_addr, imem_req, instr_valid);
    end
    $display("latest: done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_async_reset();
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_0500;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin
      bad++; $display("FAIL flush_enter req=%b addr=%h exp=1/400", imem_req, imem_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0) begin
      bad++; $display("FAIL async_reset req=%b valid=%b pc=%h exp=0/0/0", imem_req, instr_valid, pc);
    end
    @(negedge clk);
    rst_n = 1'b1; imem_ready = 1'b1;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL post_reset req=%b addr=%h exp=1/0", imem_req, imem_addr);
    end
    $display("async_reset: done total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_flush();
    test_misalign();
    test_wrap();
    test_latest_wins();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the address fetched first after reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port imem_req, output, 1 bit: request to instruction memory.
REQ-005 Port imem_addr, output, 32 bits: word-aligned fetch address.
REQ-006 Port imem_ready, input, 1 bit: memory accepts the request; imem_rdata is valid in this same cycle.
REQ-007 Port imem_rdata, input, 32 bits: fetched instruction word.
REQ-008 Port redirect_valid, input, 1 bit: a branch or jump target must replace the sequential PC.
REQ-009 Port redirect_target, input, 32 bits: the new PC, computed downstream from imm.
REQ-010 Port instr_ready, input, 1 bit: the decode/immediate stage accepts the instruction.
REQ-011 Port instr_valid, output, 1 bit: instruction and pc hold a valid fetched pair.
REQ-012 Port instruction, output, 32 bits: fetched word that feeds decode and immediate generation.
REQ-013 Port pc, output, 32 bits: address of the instruction.
REQ-014 Port misalign_err, output, 1 bit: one-cycle pulse when a redirect target is not word-aligned.

Function
REQ-015 FSM states: IDLE, FETCH, HOLD, FLUSH; imem_req = 1 exactly in FETCH and FLUSH.
REQ-016 IDLE -> FETCH on the first clock edge after rst_n goes high.
REQ-017 In FETCH: imem_addr = pc_q; on imem_ready, imem_rdata is registered into instruction, instr_valid = 1 next cycle, and the FSM moves to HOLD.
REQ-018 In HOLD: on instr_valid && instr_ready, pc_q <= pc_q + 4, instr_valid <= 0, and the FSM moves to FETCH; otherwise instruction, pc and instr_valid stay stable.
REQ-019 Throughput: at most one instruction per 2 cycles; latency from imem_ready to instr_valid is 1 cycle.
REQ-020 PC increment wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-021 Redirect in HOLD: the held instruction is dropped and not delivered; pc_q <= target; instr_valid <= 0; the FSM moves to FETCH. Redirect takes priority over a same-cycle accept.
REQ-022 Redirect in FETCH with imem_ready = 1: the returned data is discarded; pc_q <= target; the FSM stays in FETCH.
REQ-023 Redirect in FETCH with imem_ready = 0: the target is stored in pending_q and the FSM moves to FLUSH; imem_req and imem_addr stay unchanged, because memory requires a stable request until ready.
REQ-024 In FLUSH: the FSM keeps requesting the old address; a new redirect overwrites pending_q (latest wins); on imem_ready, data is discarded, pc_q <= pending_q (or the same-cycle target), and the FSM moves to FETCH.
REQ-025 Redirect in IDLE is ignored.
REQ-026 Misaligned target (target[1:0] != 0): bits [1:0] are forced to 0, the redirect is otherwise honoured, and misalign_err pulses for 1 cycle.
REQ-027 When instr_valid = 0, instruction outputs NOP 32'h0000_0013.

Reset
REQ-028 With rst_n low, state = IDLE, pc_q = RESET_PC, pending_q = 0, instr_valid = 0, instruction = NOP, imem_req = 0, misalign_err = 0.
REQ-029 Reset asserted mid-operation aborts any request and any flush immediately (asynchronously); no held instruction survives.

Structure
REQ-030 Package rv_fetch_pkg SHALL hold the state enum, NOP_INSTR, INSTR_BYTES = 4 and the default RESET_PC.
REQ-031 One sub-module, pc_register, SHALL hold pc_q with async reset, increment and load-target controls.

Verification
REQ-032 Reset release, imem_ready tied high, instr_ready high: imem_addr = 0, 4, 8 on consecutive fetches, and instr_valid rises one cycle after each ready.
REQ-033 HOLD with instr_ready = 0 for 5 cycles: instruction and pc are stable for all 5 cycles, and imem_req = 0.
REQ-034 Redirect to 32'h0000_0100 in FETCH while imem_ready = 0 for 3 cycles: imem_addr stays at the old address until ready, that data is dropped, and the next fetch is at 32'h100.
REQ-035 Redirect to 32'h0000_0202: next fetch is at 32'h200 and misalign_err pulses for exactly 1 cycle.
REQ-036 pc = 32'hFFFF_FFFC accepted: next imem_addr = 32'h0000_0000.
REQ-037 rst_n pulled low in FLUSH: imem_req drops without a clock edge, and after release the first fetch is at RESET_PC.
